// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative signed multiply/divide unit holding the MIPS HI/LO registers.
// MULT and DIV both take a fixed WIDTH+1 clocks from the accepting edge to
// the edge that writes HI/LO and pulses done.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - request pulse, only looked at while idle
//   op       - 0 = signed multiply, 1 = signed divide
//   a        - rs operand (multiplicand / dividend)
//   b        - rt operand (multiplier / divisor)
//   busy     - high while an operation is in flight
//   done     - one-cycle completion pulse
//   div_zero - last accepted divide had a zero divisor
//   hi, lo   - HI and LO result registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FINISH
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             op_q;
    logic             neg_a;
    logic             neg_b;
    logic             dz_pending;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot_signed;
    logic [WIDTH-1:0]   rem_signed;

    // Per-iteration arithmetic and final sign correction.
    // work_hi:work_lo is the shared working pair: for MULT it is the
    // partial product with the multiplier shifting out the bottom, for DIV
    // it is the partial remainder with the dividend shifting out the top
    // and quotient bits shifting in at the bottom. 'operand' holds the
    // multiplicand or divisor magnitude. The remainder is always below the
    // divisor, so the subtraction only needs the low WIDTH bits.
    always_comb begin
        mag_a       = a[WIDTH-1] ? -a : a;
        mag_b       = b[WIDTH-1] ? -b : b;
        mult_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
        div_shift   = {work_hi, work_lo[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, operand});
        div_sub     = div_shift[WIDTH-1:0] - operand;
        prod_mag    = {work_hi, work_lo};
        prod_signed = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
        quot_signed = (neg_a ^ neg_b) ? -work_lo : work_lo;
        rem_signed  = neg_a ? -work_hi : work_hi;
    end

    // Control FSM and datapath registers.
    // A zero divisor skips straight to FINISH so done follows one clock
    // after the accepting edge without touching HI/LO. The overflow case
    // (most-negative / -1) needs no special handling: its magnitude
    // quotient negates back onto itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            op_q       <= 1'b0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            dz_pending <= 1'b0;
            operand    <= '0;
            work_hi    <= '0;
            work_lo    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        neg_a      <= a[WIDTH-1];
                        neg_b      <= b[WIDTH-1];
                        operand    <= op ? mag_b : mag_a;
                        work_lo    <= op ? mag_a : mag_b;
                        work_hi    <= '0;
                        count      <= '0;
                        div_zero   <= 1'b0;
                        busy       <= 1'b1;
                        dz_pending <= op && (b == '0);
                        if (!op)
                            state <= MULT;
                        else if (b == '0)
                            state <= FINISH;
                        else
                            state <= DIV;
                    end
                end
                MULT: begin
                    work_hi <= mult_sum[WIDTH:1];
                    work_lo <= {mult_sum[0], work_lo[WIDTH-1:1]};
                    count   <= count + CW'(1);
                    if (count == CW'(WIDTH - 1))
                        state <= FINISH;
                end
                DIV: begin
                    if (div_ge) begin
                        work_hi <= div_sub;
                        work_lo <= {work_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi <= div_shift[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (dz_pending) begin
                        div_zero <= 1'b1;
                    end else if (op_q) begin
                        lo <= quot_signed;
                        hi <= rem_signed;
                    end else begin
                        {hi, lo} <= prod_signed;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. A timer-and-arithmetic reference
// model predicts busy/done/div_zero/hi/lo every cycle; directed scenarios
// add literal expectations for results, latency and done-pulse counts.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    // Reference model state
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_dz   = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          m_cnt  = 0;
    logic        p_dz   = 1'b0;
    logic [31:0] p_hi   = '0;
    logic [31:0] p_lo   = '0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural result of one operation from plain signed arithmetic
    function automatic void model_result(input logic op_in, input logic [31:0] aa,
                                         input logic [31:0] bb, output logic dz,
                                         output logic [31:0] rh, output logic [31:0] rl);
        logic signed [63:0] p;
        int sa;
        int sb;
        dz = 1'b0;
        rh = '0;
        rl = '0;
        if (!op_in) begin
            p  = $signed({{32{aa[31]}}, aa}) * $signed({{32{bb[31]}}, bb});
            rh = p[63:32];
            rl = p[31:0];
        end else if (bb == 32'd0) begin
            dz = 1'b1;
        end else begin
            sa = $signed(aa);
            sb = $signed(bb);
            if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                rl = 32'h8000_0000;
                rh = 32'h0;
            end else begin
                rl = sa / sb;
                rh = sa % sb;
            end
        end
    endfunction

    // Cycle model: an accepted start arms a countdown of WIDTH+1 edges
    // (1 for a zero divisor); the edge where it expires commits the result.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dz   = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_cnt  = 0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (p_dz)
                        m_dz = 1'b1;
                    else begin
                        m_hi = p_hi;
                        m_lo = p_lo;
                    end
                end
            end else if (start) begin
                model_result(op, a, b, p_dz, p_hi, p_lo);
                m_dz   = 1'b0;
                m_busy = 1'b1;
                m_cnt  = p_dz ? 1 : WIDTH + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s @%0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            checkOutput("cyc_done", {63'd0, done}, {63'd0, m_done});
            checkOutput("cyc_div_zero", {63'd0, div_zero}, {63'd0, m_dz});
            checkOutput("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            checkOutput("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    // Caller sits just after a rising edge; the next edge accepts, after
    // which the operand inputs are scrambled to prove they were latched.
    task automatic applyStimulus(input logic op_in, input logic [31:0] aa, input logic [31:0] bb);
        op    = op_in;
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom_range(0, 1));
        a     = $urandom;
        b     = $urandom;
    endtask

    // Edges from the accepting edge to done, bounded; -1 on timeout
    task automatic waitDone(output int lat);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;

        // Reset state
        repeat (2) @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_hi", {32'd0, hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 7 * -3
        applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD);
        waitDone(lat);
        checkOutput("mul1_latency", 64'(lat), 64'd33);
        checkOutput("mul1_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        checkOutput("mul1_lo", {32'd0, lo}, 64'hFFFF_FFEB);

        // -7 / 2
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        waitDone(lat);
        checkOutput("div1_latency", 64'(lat), 64'd33);
        checkOutput("div1_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        checkOutput("div1_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        // Overflow divide
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(lat);
        checkOutput("ovf_lo", {32'd0, lo}, 64'h8000_0000);
        checkOutput("ovf_hi", {32'd0, hi}, 64'h0);
        checkOutput("ovf_dz", {63'd0, div_zero}, 64'd0);

        // 7 / -2
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
        waitDone(lat);
        checkOutput("div2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        checkOutput("div2_hi", {32'd0, hi}, 64'h1);

        // Preload hi=0x11 lo=0x22 via 0x66 * 0x2AAAAAAB, then divide by zero
        applyStimulus(1'b0, 32'h66, 32'h2AAA_AAAB);
        waitDone(lat);
        checkOutput("pre_hi", {32'd0, hi}, 64'h11);
        checkOutput("pre_lo", {32'd0, lo}, 64'h22);
        applyStimulus(1'b1, 32'd5, 32'd0);
        waitDone(lat);
        checkOutput("dz_latency", 64'(lat), 64'd1);
        checkOutput("dz_flag", {63'd0, div_zero}, 64'd1);
        checkOutput("dz_hi", {32'd0, hi}, 64'h11);
        checkOutput("dz_lo", {32'd0, lo}, 64'h22);
        applyStimulus(1'b1, 32'd9, 32'd2);
        checkOutput("dz_cleared", {63'd0, div_zero}, 64'd0);
        waitDone(lat);
        checkOutput("div3_lo", {32'd0, lo}, 64'd4);
        checkOutput("div3_hi", {32'd0, hi}, 64'd1);

        // -1 * -1 with a start re-asserted while busy
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        ndone = 0;
        lat   = -1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                lat = i;
            end
            if (i == 9) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 32'd3;
                b     = 32'd3;
            end
            if (i == 10)
                start = 1'b0;
        end
        checkOutput("ign_ndone", 64'(ndone), 64'd1);
        checkOutput("ign_latency", 64'(lat), 64'd33);
        checkOutput("ign_hi", {32'd0, hi}, 64'h0);
        checkOutput("ign_lo", {32'd0, lo}, 64'h1);

        // Back-to-back: divide started in the multiply's done cycle
        applyStimulus(1'b0, 32'd6, 32'd7);
        waitDone(lat);
        checkOutput("b2b_mul_lo", {32'd0, lo}, 64'd42);
        applyStimulus(1'b1, 32'd100, 32'd7);
        waitDone(lat);
        checkOutput("b2b_div_latency", 64'(lat), 64'd33);
        checkOutput("b2b_div_lo", {32'd0, lo}, 64'd14);
        checkOutput("b2b_div_hi", {32'd0, hi}, 64'd2);

        // Asynchronous reset in the middle of a divide
        applyStimulus(1'b1, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arst_busy", {63'd0, busy}, 64'd0);
        checkOutput("arst_done", {63'd0, done}, 64'd0);
        checkOutput("arst_hi", {32'd0, hi}, 64'd0);
        checkOutput("arst_lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done)
                ndone++;
        end
        checkOutput("arst_no_done", 64'(ndone), 64'd0);
        applyStimulus(1'b0, 32'd2, 32'd3);
        waitDone(lat);
        checkOutput("arst_mul_lo", {32'd0, lo}, 64'd6);
        checkOutput("arst_mul_hi", {32'd0, hi}, 64'd0);

        @(negedge clk);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed 32-bit multiply/divide unit. It executes MIPS MULT/DIV and holds the HI/LO result registers.
- It sits downstream of the multicycle control unit. Control asserts start with op, then holds its FSM in a wait state until done.
- The datapath reads HI/LO for MFHI/MFLO.
- div_zero is reported back to control for exception handling.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request pulse from control; sampled only while idle
- op  input  1  0 = signed multiply, 1 = signed divide
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  last accepted divide had divisor 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst low, async): state=IDLE. busy=0, done=0, div_zero=0, hi=0, lo=0. Iteration counter cleared.
- Reset mid-operation: the operation is aborted and no result is written. Release from reset returns to IDLE.
- States: IDLE, MULT, DIV, FINISH.
- IDLE with start=1 at edge E0:
  - a, b and op are latched; operand signs are recorded.
  - Operands are converted to magnitudes.
  - div_zero is cleared.
  - busy=1 from E0.
  - Next state is MULT (op=0) or DIV (op=1 and b!=0).
- Divide by zero (op=1, b=0 at E0):
  - No iteration.
  - At E0+1: done=1, div_zero=1, busy=0, state=IDLE.
  - hi/lo are unchanged.
- MULT and DIV each run exactly WIDTH iterations, one per clock.
  - MULT: unsigned shift-add on magnitudes.
  - DIV: unsigned restoring divide on magnitudes.
  - The counter counts 0..WIDTH-1. At the last iteration the state moves to FINISH.
- FINISH, one cycle. At edge E0+WIDTH+1:
  - Sign correction is applied.
  - hi/lo are written.
  - done=1 for exactly one cycle.
  - busy=0.
  - state=IDLE.
- Fixed latency: the start edge to the result/done edge is WIDTH+1 clocks (33 for WIDTH=32), independent of operand values.
- MULT result: {hi,lo} = full 2*WIDTH signed product of a and b.
- DIV result:
  - lo = quotient truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Invariant: a = lo*b + hi.
- DIV overflow (a = most-negative value, b = -1): lo = 0x80000000, hi = 0. No flag is raised.
- start while busy=1: ignored. The latched operands and the in-flight operation are unaffected.
- start in the done cycle: accepted, because the state is already IDLE. A back-to-back operation is permitted.
- hi/lo hold their value between operations, and also while an operation is in progress (the old value stays visible until FINISH).
- div_zero holds until the next accepted start.
- op, a and b are don't-care except at the accepting edge.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

Test Plan:
- Reset, then op=0, a=7, b=0xFFFFFFFD (-3), 1-cycle start pulse:
  - busy=1 for 33 cycles.
  - done pulses once at edge E0+33.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- op=1, a=0xFFFFFFF9 (-7), b=2:
  - After 33 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - Then a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
- op=1, a=5, b=0 with hi=0x11, lo=0x22 preloaded from a prior multiply:
  - At E0+1, done=1 and div_zero=1.
  - hi=0x11 and lo=0x22 are unchanged.
  - A subsequent valid start clears div_zero.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF, with start re-asserted at cycle 10 using a=3, b=3:
  - The second start is ignored.
  - Result is hi=0, lo=1 at E0+33.
  - Only one done pulse occurs.
- Back-to-back: start a 6×7 multiply, then assert start (op=1, a=100, b=7) in its done cycle:
  - lo=42 at the first done.
  - lo=14, hi=2 exactly 33 cycles later.
- Assert rst low at cycle 15 of a divide, asynchronously mid-cycle:
  - busy, done, hi and lo go to 0 immediately.
  - After release, no done pulse appears.
  - A new multiply 2×3 gives lo=6.
